// File: rtl/gauss_blur_reader.sv
// 3x3 Gaussian blur over an image read from a 1-cycle-latency word memory; streams one pixel per location.
// Latency: 11 cycles per pixel (9 taps, 1 drain, 1 emit); done one cycle after the last pixel.
// Backpressure: none; pix_valid is a single-cycle pulse and the consumer must accept it.
module gauss_blur_reader #(
    parameter int IMG_W = 5,
    parameter int IMG_H = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mem_trigger,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    output logic [4:0]  pix_index,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, FINISH} state_t;

    localparam logic [4:0] W5    = 5'(IMG_W);
    localparam logic [4:0] WMAX  = 5'(IMG_W - 1);
    localparam logic [4:0] HMAX  = 5'(IMG_H - 1);
    localparam logic [4:0] LAST  = 5'(IMG_W * IMG_H - 1);

    state_t      state_q, state_d;
    logic [3:0]  tap_q;
    logic [4:0]  col_q, row_q, pix_q;
    logic [11:0] acc_q;
    logic [7:0]  pix_out_q;
    logic [4:0]  pix_index_q;

    logic [1:0]  ysel, xsel;
    logic [4:0]  ytap, xtap;
    logic [3:0]  dtap;
    logic [1:0]  wshift;
    logic [11:0] acc_next, sum_rnd;
    logic        unused_hi;

    assign unused_hi   = ^mem_dout[31:8];
    assign mem_trigger = 1'b0;
    assign mem_din     = 32'h0;
    assign busy        = (state_q != IDLE);
    assign pix_valid   = (state_q == EMIT);
    assign done        = (state_q == FINISH);
    assign pix_out     = pix_out_q;
    assign pix_index   = pix_index_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (tap_q == 4'd8) state_d = DRAIN;
            DRAIN:   state_d = EMIT;
            EMIT:    state_d = (pix_q == LAST) ? FINISH : FETCH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tap row/column selector: 0 = minus one, 1 = same, 2 = plus one (clamped at the borders).
    always_comb begin
        ysel = 2'd1;
        xsel = 2'd1;
        case (tap_q)
            4'd0: begin ysel = 2'd0; xsel = 2'd0; end
            4'd1: begin ysel = 2'd0; xsel = 2'd1; end
            4'd2: begin ysel = 2'd0; xsel = 2'd2; end
            4'd3: begin ysel = 2'd1; xsel = 2'd0; end
            4'd4: begin ysel = 2'd1; xsel = 2'd1; end
            4'd5: begin ysel = 2'd1; xsel = 2'd2; end
            4'd6: begin ysel = 2'd2; xsel = 2'd0; end
            4'd7: begin ysel = 2'd2; xsel = 2'd1; end
            4'd8: begin ysel = 2'd2; xsel = 2'd2; end
            default: begin ysel = 2'd1; xsel = 2'd1; end
        endcase
        case (ysel)
            2'd0:    ytap = (row_q == 5'd0) ? row_q : row_q - 5'd1;
            2'd2:    ytap = (row_q == HMAX) ? row_q : row_q + 5'd1;
            default: ytap = row_q;
        endcase
        case (xsel)
            2'd0:    xtap = (col_q == 5'd0) ? col_q : col_q - 5'd1;
            2'd2:    xtap = (col_q == WMAX) ? col_q : col_q + 5'd1;
            default: xtap = col_q;
        endcase
        mem_addr = (state_q == FETCH) ? (ytap * W5 + xtap) : 5'd0;
    end

    // Data arriving now belongs to the tap addressed one cycle earlier.
    always_comb begin
        dtap = (state_q == DRAIN) ? 4'd8 : 4'(tap_q - 4'd1);
        case (dtap)
            4'd4:                      wshift = 2'd2;
            4'd1, 4'd3, 4'd5, 4'd7:    wshift = 2'd1;
            default:                   wshift = 2'd0;
        endcase
        acc_next = acc_q + ({4'b0, mem_dout[7:0]} << wshift);
        sum_rnd  = acc_next + 12'd8;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_q       <= '0;
            acc_q       <= '0;
            pix_out_q   <= '0;
            pix_index_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    tap_q <= '0;
                    col_q <= '0;
                    row_q <= '0;
                    pix_q <= '0;
                end
                FETCH: begin
                    acc_q <= (tap_q == 4'd0) ? 12'd0 : acc_next;
                    tap_q <= tap_q + 4'd1;
                end
                DRAIN: begin
                    acc_q       <= acc_next;
                    pix_out_q   <= 8'(sum_rnd >> 4);
                    pix_index_q <= pix_q;
                end
                EMIT: begin
                    tap_q <= '0;
                    if (pix_q != LAST) begin
                        pix_q <= pix_q + 5'd1;
                        if (col_q == WMAX) begin
                            col_q <= '0;
                            row_q <= row_q + 5'd1;
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gauss_blur_reader.sv
// Randomized and directed checks of gauss_blur_reader against an image-level blur model.
module tb_gauss_blur_reader;
    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;
    localparam int DONE_CYC = 11 * N + 1;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        mem_trigger;
    logic [4:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic [4:0]  pix_index;
    logic        busy, done;

    gauss_blur_reader #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_trigger(mem_trigger), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .pix_out(pix_out), .pix_valid(pix_valid), .pix_index(pix_index),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:31];
    always @(posedge clk) mem_dout <= mem[mem_addr];

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] last_out;
    logic [4:0] last_idx;
    logic [7:0] got [0:N-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [7:0] model_pix(input int p);
        int x, y, sum, wt;
        logic [31:0] word;
        x = p % W;
        y = p / W;
        sum = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                wt = ((dy == 0) ? 2 : 1) * ((dx == 0) ? 2 : 1);
                word = mem[clampi(y + dy, H - 1) * W + clampi(x + dx, W - 1)];
                sum += wt * int'(word[7:0]);
            end
        return 8'((sum + 8) / 16);
    endfunction

    function automatic logic [4:0] tap_addr(input int p, input int o);
        int x, y;
        x = clampi(p % W + (o % 3) - 1, W - 1);
        y = clampi(p / W + (o / 3) - 1, H - 1);
        return 5'(y * W + x);
    endfunction

    // Expected outputs in cycle cyc of a run whose start was sampled in cycle 0.
    task automatic check_cycle(input int cyc);
        int p, o;
        bit in_run, exp_valid;
        p = (cyc >= 1) ? (cyc - 1) / 11 : 0;
        o = (cyc >= 1) ? (cyc - 1) % 11 : 0;
        in_run = (cyc >= 1) && (p < N);
        exp_valid = in_run && (o == 10);
        if (exp_valid) begin
            last_out = model_pix(p);
            last_idx = 5'(p);
            got[p] = pix_out;
        end
        chk("pix_valid", {31'b0, pix_valid}, {31'b0, exp_valid});
        chk("done", {31'b0, done}, {31'b0, cyc == DONE_CYC});
        chk("busy", {31'b0, busy}, {31'b0, (cyc >= 1) && (cyc <= DONE_CYC)});
        chk("pix_out", {24'b0, pix_out}, {24'b0, last_out});
        chk("pix_index", {27'b0, pix_index}, {27'b0, last_idx});
        chk("mem_trigger", {31'b0, mem_trigger}, 32'h0);
        chk("mem_din", mem_din, 32'h0);
        if (in_run && o <= 8)
            chk("mem_addr_tap", {27'b0, mem_addr}, {27'b0, tap_addr(p, o)});
        else if (!in_run)
            chk("mem_addr_idle", {27'b0, mem_addr}, 32'h0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_out"}, {24'b0, pix_out}, 32'h0);
        chk({tag, "_pix_valid"}, {31'b0, pix_valid}, 32'h0);
        chk({tag, "_pix_index"}, {27'b0, pix_index}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_done"}, {31'b0, done}, 32'h0);
        chk({tag, "_mem_addr"}, {27'b0, mem_addr}, 32'h0);
        chk({tag, "_mem_trigger"}, {31'b0, mem_trigger}, 32'h0);
        chk({tag, "_mem_din"}, mem_din, 32'h0);
    endtask

    // Runs one image; noisy adds stray start pulses while busy; abort_cyc>0 resets in that cycle.
    task automatic run(input bit noisy, input int abort_cyc);
        int lastc;
        lastc = (abort_cyc > 0) ? abort_cyc : DONE_CYC + 2;
        for (int c = 0; c <= lastc; c++) begin
            @(negedge clk);
            check_cycle(c);
            start = (c == 0) || (noisy && c >= 1 && c <= DONE_CYC && $urandom_range(0, 2) == 0);
        end
        if (abort_cyc > 0) begin
            rst = 1'b1;
            start = 1'b0;
            @(negedge clk);
            check_zero("abort");
            rst = 1'b0;
            last_out = 8'h0;
            last_idx = 5'h0;
            repeat (3) begin
                @(negedge clk);
                chk("abort_no_done", {31'b0, done}, 32'h0);
            end
        end
        start = 1'b0;
    endtask

    task automatic fill(input logic [31:0] val);
        for (int i = 0; i < 32; i++) mem[i] = val;
    endtask

    initial begin
        fill(32'h0);
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        start = 1'b0;
        last_out = 8'h0;
        last_idx = 5'h0;

        fill(32'h40);
        run(1'b0, 0);
        chk("const_pix0", {24'b0, got[0]}, 32'h40);
        chk("const_pix24", {24'b0, got[24]}, 32'h40);

        fill(32'h0);
        mem[12] = 32'hFF;
        run(1'b0, 0);
        chk("imp_12", {24'b0, got[12]}, 32'h40);
        chk("imp_7", {24'b0, got[7]}, 32'h20);
        chk("imp_11", {24'b0, got[11]}, 32'h20);
        chk("imp_13", {24'b0, got[13]}, 32'h20);
        chk("imp_17", {24'b0, got[17]}, 32'h20);
        chk("imp_6", {24'b0, got[6]}, 32'h10);
        chk("imp_8", {24'b0, got[8]}, 32'h10);
        chk("imp_16", {24'b0, got[16]}, 32'h10);
        chk("imp_18", {24'b0, got[18]}, 32'h10);
        chk("imp_0", {24'b0, got[0]}, 32'h00);
        chk("imp_24", {24'b0, got[24]}, 32'h00);

        fill(32'h0);
        mem[0] = 32'hFF;
        run(1'b0, 0);
        chk("corner_0", {24'b0, got[0]}, 32'h8F);
        chk("corner_1", {24'b0, got[1]}, 32'h30);
        chk("corner_5", {24'b0, got[5]}, 32'h30);
        chk("corner_6", {24'b0, got[6]}, 32'h10);

        fill(32'hFFFFFF10);
        run(1'b1, 0);
        chk("hi_bits_5", {24'b0, got[5]}, 32'h10);
        chk("hi_bits_24", {24'b0, got[24]}, 32'h10);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            run(1'b1, 0);
        end

        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        run(1'b1, 56);
        run(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
